// File: rtl/div_ctrl.sv
// div_ctrl - sequencer between the M-extension execute stage and an unsigned
// iterative divider.
//
// Decodes DIV/DIVU/REM/REMU, converts signed operands to magnitudes, and
// answers the RISC-V special cases without using the divider: divide by zero
// and signed overflow. When REUSE_EN is set and an op repeats the operands
// and signedness of the last launched op, the stored quotient/remainder pair
// answers it. It owns the divider load/resp handshake. After a flush it
// drains the divider, because the divider cannot be aborted.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        execute-stage handshake (ready only in IDLE)
//   req_funct3, req_rs1/rs2    op select and operands
//   flush                      kill in-flight op, invalidate reuse tag
//   resp_valid/resp_data       one-cycle result pulse, data held until next
//   div_load                   one-cycle launch pulse to the divider
//   div_dividend/div_divisor   unsigned magnitudes, stable while dividing
//   div_quotient/remainder     divider results, sampled on div_resp
//   div_resp                   divider done pulse
module div_ctrl #(
  parameter bit REUSE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        div_load,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_resp
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_FIX, S_RESP, S_DRAIN
  } state_t;

  state_t              state;
  logic                rem_sel;
  logic                neg1_p0, neg2_p0;
  logic [DATA_W-1:0]   q_p1, r_p1;
  logic [DATA_W-1:0]   fix_q, fix_r;
  logic [DATA_W-1:0]   st_q, st_r;
  logic [DATA_W-1:0]   tag_rs1, tag_rs2;
  logic                tag_sgn, tag_vld;
  logic                vld_p2;

  // Two's-complement negate; 0x80000000 maps to itself and is then read as
  // an unsigned magnitude by the divider.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] sx;
    sx = $signed(x);
    return $unsigned(-sx);
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x,
                                            input logic neg);
    return neg ? negate(x) : x;
  endfunction

  // Request decode (used only in IDLE)
  logic req_sgn, req_neg1, req_neg2, req_div0, req_ovf, req_hit;
  logic unused_f3;

  assign unused_f3 = req_funct3[2];
  assign req_sgn   = ~req_funct3[0];
  assign req_neg1  = req_sgn & req_rs1[DATA_W-1];
  assign req_neg2  = req_sgn & req_rs2[DATA_W-1];
  assign req_div0  = (req_rs2 == '0);
  assign req_ovf   = req_sgn & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
  assign req_hit   = REUSE_EN & tag_vld & (tag_rs1 == req_rs1) &
                     (tag_rs2 == req_rs2) & (tag_sgn == req_sgn);

  // Sign fix-up of the raw divider result
  always_comb begin
    fix_q = mag(q_p1, neg1_p0 ^ neg2_p0);
    fix_r = mag(r_p1, neg1_p0);
  end

  assign req_ready  = (state == S_IDLE);
  // A flush in the RESP cycle suppresses the pulse.
  assign resp_valid = vld_p2 & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rem_sel      <= 1'b0;
      neg1_p0      <= 1'b0;
      neg2_p0      <= 1'b0;
      q_p1         <= '0;
      r_p1         <= '0;
      st_q         <= '0;
      st_r         <= '0;
      tag_rs1      <= '0;
      tag_rs2      <= '0;
      tag_sgn      <= 1'b0;
      tag_vld      <= 1'b0;
      vld_p2       <= 1'b0;
      resp_data    <= '0;
      div_load     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      div_load <= 1'b0;
      vld_p2   <= 1'b0;
      if (flush) tag_vld <= 1'b0;
      unique case (state)
        // p0: accept, classify, latch operands
        S_IDLE: begin
          if (req_valid && !flush) begin
            rem_sel <= req_funct3[1];
            neg1_p0 <= req_neg1;
            neg2_p0 <= req_neg2;
            if (req_div0) begin
              resp_data <= req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
              vld_p2    <= 1'b1;
              state     <= S_RESP;
            end else if (req_ovf) begin
              resp_data <= req_funct3[1] ? 32'h0 : req_rs1;
              vld_p2    <= 1'b1;
              state     <= S_RESP;
            end else if (req_hit) begin
              resp_data <= req_funct3[1] ? st_r : st_q;
              vld_p2    <= 1'b1;
              state     <= S_RESP;
            end else begin
              div_dividend <= mag(req_rs1, req_neg1);
              div_divisor  <= mag(req_rs2, req_neg2);
              tag_rs1      <= req_rs1;
              tag_rs2      <= req_rs2;
              tag_sgn      <= req_sgn;
              tag_vld      <= 1'b0;
              div_load     <= 1'b1;
              state        <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: state <= flush ? S_DRAIN : S_WAIT;
        // p1: capture divider result
        S_WAIT: begin
          if (flush) begin
            // Divider finishing in the flush cycle leaves nothing to drain.
            state <= div_resp ? S_IDLE : S_DRAIN;
          end else if (div_resp) begin
            q_p1  <= div_quotient;
            r_p1  <= div_remainder;
            state <= S_FIX;
          end
        end
        // p2: sign fix-up, store for reuse
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            st_q      <= fix_q;
            st_r      <= fix_r;
            tag_vld   <= 1'b1;
            resp_data <= rem_sel ? fix_r : fix_q;
            vld_p2    <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        S_DRAIN: if (div_resp) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        div_load;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient, div_remainder;
  logic        div_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_cnt = 0;
  int rv_cnt = 0;
  int rv_cyc = 0;
  int dresp_cyc = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  always #5 clk = ~clk;

  div_ctrl #(.REUSE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_ready(req_ready), .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .div_load(div_load),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_resp(div_resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Divider model: fixed latency, computes from the held operands at finish.
  logic       busy;
  logic [2:0] dcnt;
  always @(posedge clk) begin
    div_resp <= 1'b0;
    if (rst) begin
      busy <= 1'b0;
      dcnt <= '0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_load) begin
      busy <= 1'b1;
      dcnt <= 3'd4;
    end else if (busy) begin
      if (dcnt == 0) begin
        busy          <= 1'b0;
        div_resp      <= 1'b1;
        div_quotient  <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
        div_remainder <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
      end else begin
        dcnt <= dcnt - 3'd1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (div_load) begin
        load_cnt <= load_cnt + 1;
        check("load_while_busy", {31'd0, busy}, 32'd0);
      end
      if (div_resp) dresp_cyc <= cyc;
      if (resp_valid) begin
        rv_cnt <= rv_cnt + 1;
        rv_cyc <= cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and check data, number of div_load pulses and timing:
  // launched ops answer 2 cycles after div_resp, others at accept+1.
  task automatic t_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_data, input int exp_loads);
    int n, l0, lat;
    logic [31:0] data;
    logic        seen;
    n = 0;
    while (!req_ready && n < 100) begin step(); n++; end
    l0 = load_cnt;
    req_valid = 1'b1; req_funct3 = f; req_rs1 = a; req_rs2 = b;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin step(); lat++; end
    seen = resp_valid;
    data = resp_data;
    check({tag, "_resp_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_data"}, data, exp_data);
    step();
    check({tag, "_loads"}, load_cnt - l0, exp_loads);
    if (exp_loads == 1) check({tag, "_gap"}, rv_cyc - dresp_cyc, 32'd2);
    else                check({tag, "_lat"}, lat, 32'd1);
  endtask

  initial begin
    int n, rv0, l0;
    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; flush = 1'b0;
    step(); step(); step();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_div_load", {31'd0, div_load}, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    rst = 1'b0;
    step();

    t_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 1);
    t_op("remu_100_7_reuse", F_REMU, 32'd100, 32'd7, 32'd2, 0);
    t_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
    t_op("rem_m7_2_reuse", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    t_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1);
    t_op("div_x_0", F_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 0);
    t_op("rem_5_0", F_REM, 32'd5, 32'd0, 32'd5, 0);
    t_op("remu_min_0", F_REMU, 32'h8000_0000, 32'd0, 32'h8000_0000, 0);
    t_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    t_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    t_op("divu_min_m1", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush while the divider is busy: drain, then repeat relaunches.
    t_op("divu_50_5", F_DIVU, 32'd50, 32'd5, 32'd10, 1);
    rv0 = rv_cnt;
    req_valid = 1'b1; req_funct3 = F_DIVU; req_rs1 = 32'd60; req_rs2 = 32'd7;
    step();
    req_valid = 1'b0;
    check("flush_launch_load", {31'd0, div_load}, 32'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (!div_resp && n < 50) begin
      check("drain_ready_low", {31'd0, req_ready}, 32'd0);
      step(); n++;
    end
    check("drain_resp_seen", {31'd0, div_resp}, 32'd1);
    check("drain_ready_at_resp", {31'd0, req_ready}, 32'd0);
    step();
    check("drain_ready_after", {31'd0, req_ready}, 32'd1);
    check("flush_no_resp", rv_cnt - rv0, 32'd0);
    t_op("divu_50_5_again", F_DIVU, 32'd50, 32'd5, 32'd10, 1);
    t_op("remu_50_5_reuse", F_REMU, 32'd50, 32'd5, 32'd0, 0);

    // Flush coinciding with an IDLE handshake drops the request and the tag.
    rv0 = rv_cnt; l0 = load_cnt;
    req_valid = 1'b1; req_funct3 = F_DIVU; req_rs1 = 32'd77; req_rs2 = 32'd3;
    flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    step(); step(); step();
    check("flush_accept_no_resp", rv_cnt - rv0, 32'd0);
    check("flush_accept_no_load", load_cnt - l0, 32'd0);
    check("flush_accept_ready", {31'd0, req_ready}, 32'd1);
    t_op("remu_50_5_tag_gone", F_REMU, 32'd50, 32'd5, 32'd0, 1);

    t_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 1);
    t_op("div_9_3_nosuse", F_DIV, 32'd9, 32'd3, 32'd3, 1);
    t_op("divu_0_5", F_DIVU, 32'd0, 32'd5, 32'd0, 1);
    check("resp_data_hold", resp_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
